// File: rtl/rf_wport_arbiter.sv
// rtl/rf_wport_arbiter.sv - register file write-port arbiter (wb/dbg round robin), post-reset clear under RF_WPORT_CLEAR_EN
module rf_wport_arbiter #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            wb_ready,
  input  logic            dbg_valid,
  input  logic [AW-1:0]   dbg_addr,
  input  logic [XLEN-1:0] dbg_data,
  output logic            dbg_ready,
  output logic            rf_we,
  output logic [AW-1:0]   rf_a3,
  output logic [XLEN-1:0] rf_wd3,
  output logic            clear_done
);

  // last_q = 1 means the most recent grant went to the debug port
  logic            last_q;
  logic            rf_we_q;
  logic [AW-1:0]   rf_a3_q;
  logic [XLEN-1:0] rf_wd3_q;

  logic            run;
  logic            accept;
  logic [AW-1:0]   wr_addr_d;
  logic [XLEN-1:0] wr_data_d;

`ifdef RF_WPORT_CLEAR_EN
  typedef enum logic {S_CLEAR, S_RUN} state_t;
  state_t          state_q;
  logic [AW-1:0]   cnt_q;
  logic            clear_done_q;

  assign run        = (state_q == S_RUN);
  assign clear_done = clear_done_q;
`else
  // Without the clear the port is open as soon as reset is released
  assign run        = !reset;
  assign clear_done = 1'b1;
`endif

  // Round robin: a lone requester wins, on contention the one not granted last wins
  always_comb begin
    wb_ready  = run && wb_valid  && (!dbg_valid || last_q);
    dbg_ready = run && dbg_valid && (!wb_valid  || !last_q);
    accept    = wb_ready || dbg_ready;
    wr_addr_d = dbg_ready ? dbg_addr : wb_addr;
    wr_data_d = dbg_ready ? dbg_data : wb_data;
  end

  // Clear sequencer and registered write-port drive
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we_q      <= 1'b0;
      rf_a3_q      <= '0;
      rf_wd3_q     <= '0;
      last_q       <= 1'b1;
`ifdef RF_WPORT_CLEAR_EN
      state_q      <= S_CLEAR;
      cnt_q        <= {{(AW-1){1'b0}}, 1'b1};
      clear_done_q <= 1'b0;
`endif
    end else begin
`ifdef RF_WPORT_CLEAR_EN
      if (state_q == S_CLEAR) begin
        // cnt wraps to zero after the top register has been issued; that
        // edge drops the final write and opens the port
        if (cnt_q == '0) begin
          rf_we_q      <= 1'b0;
          state_q      <= S_RUN;
          clear_done_q <= 1'b1;
        end else begin
          rf_we_q  <= 1'b1;
          rf_a3_q  <= cnt_q;
          rf_wd3_q <= '0;
          cnt_q    <= cnt_q + 1'b1;
        end
      end else
`endif
      begin
        // x0 writes are accepted but never strobe the register file
        rf_we_q <= accept && (wr_addr_d != '0);
        if (accept) begin
          rf_a3_q  <= wr_addr_d;
          rf_wd3_q <= wr_data_d;
          last_q   <= dbg_ready;
        end
      end
    end
  end

  assign rf_we  = rf_we_q;
  assign rf_a3  = rf_a3_q;
  assign rf_wd3 = rf_wd3_q;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb/tb_rf_wport_arbiter.sv - self-checking bench for rf_wport_arbiter
module tb_rf_wport_arbiter;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 1 << AW;
`ifdef RF_WPORT_CLEAR_EN
  localparam int OPEN_EDGE = NREG;
`else
  localparam int OPEN_EDGE = 0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            wb_valid = 1'b0;
  logic [AW-1:0]   wb_addr = '0;
  logic [XLEN-1:0] wb_data = '0;
  logic            dbg_valid = 1'b0;
  logic [AW-1:0]   dbg_addr = '0;
  logic [XLEN-1:0] dbg_data = '0;
  logic            wb_ready, dbg_ready, rf_we, clear_done;
  logic [AW-1:0]   rf_a3;
  logic [XLEN-1:0] rf_wd3;

  rf_wport_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .dbg_valid(dbg_valid), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd3(rf_wd3), .clear_done(clear_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: edge count since reset release decides the phase; edges 1..NREG-1 are
  // clear writes, the port opens once OPEN_EDGE edges have passed.
  int              m_k = 0;
  logic            m_last = 1'b1;
  logic            m_we = 1'b0;
  logic [AW-1:0]   m_a3 = '0;
  logic [XLEN-1:0] m_wd3 = '0;

  function automatic logic m_open();
    return !reset && (m_k >= OPEN_EDGE);
  endfunction
  function automatic logic m_gw();
    return m_open() && wb_valid && (!dbg_valid || m_last);
  endfunction
  function automatic logic m_gd();
    return m_open() && dbg_valid && (!wb_valid || !m_last);
  endfunction
  function automatic logic m_done();
    return (OPEN_EDGE == 0) || (!reset && m_k >= OPEN_EDGE);
  endfunction

  always @(posedge clk or posedge reset) begin
    logic gw, gd;
    if (reset) begin
      m_k = 0; m_last = 1'b1; m_we = 1'b0; m_a3 = '0; m_wd3 = '0;
    end else begin
      gw = m_gw();
      gd = m_gd();
      m_k = m_k + 1;
      if (OPEN_EDGE != 0 && m_k <= NREG - 1) begin
        m_we = 1'b1; m_a3 = AW'(m_k); m_wd3 = '0;
      end else if (gw) begin
        m_we = (wb_addr != 0); m_a3 = wb_addr; m_wd3 = wb_data; m_last = 1'b0;
      end else if (gd) begin
        m_we = (dbg_addr != 0); m_a3 = dbg_addr; m_wd3 = dbg_data; m_last = 1'b1;
      end else begin
        m_we = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("wb_ready", wb_ready, m_gw());
    check("dbg_ready", dbg_ready, m_gd());
    check("rf_we", rf_we, m_we);
    check("rf_a3", rf_a3, m_a3);
    check("rf_wd3", rf_wd3, m_wd3);
    check("clear_done", clear_done, m_done());
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic first_is_dbg;
  logic exp_dbg;

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

`ifdef RF_WPORT_CLEAR_EN
    // Interrupt the clear during its 10th write
    repeat (10) @(posedge clk);
    #3;
    check("pre_reset_a3", rf_a3, 10);
    check("pre_reset_we", rf_we, 1);
    reset = 1'b1;
    #1;
    check("async_we", rf_we, 0);
    check("async_a3", rf_a3, 0);
    check("async_wd3", rf_wd3, 0);
    check("async_done", clear_done, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    step();
    check("restart_a3", rf_a3, 1);
    check("restart_we", rf_we, 1);
    repeat (30) step();
    check("last_clear_a3", rf_a3, 31);
    check("last_clear_we", rf_we, 1);
    check("last_clear_done", clear_done, 0);
    step();
    check("post_clear_we", rf_we, 0);
    check("post_clear_done", clear_done, 1);
    first_is_dbg = 1'b0;
`else
    check("noclear_done", clear_done, 1);
    wb_valid = 1'b1; wb_addr = 7; wb_data = 32'h0000_0077;
    #1;
    check("noclear_wb_ready", wb_ready, 1);
    step();
    wb_valid = 1'b0;
    check("noclear_we", rf_we, 1);
    check("noclear_a3", rf_a3, 7);
    first_is_dbg = 1'b1;
`endif

    // Continuous dual contention: grants must alternate
    wb_valid = 1'b1; wb_addr = 1; wb_data = 32'h11;
    dbg_valid = 1'b1; dbg_addr = 2; dbg_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      exp_dbg = first_is_dbg ^ (i % 2 == 1);
      #2;
      check("dual_one_ready", int'(wb_ready) + int'(dbg_ready), 1);
      check("dual_dbg_ready", dbg_ready, exp_dbg);
      step();
      check("dual_a3", rf_a3, exp_dbg ? 2 : 1);
      check("dual_wd3", rf_wd3, exp_dbg ? 32'h22 : 32'h11);
    end
    wb_valid = 1'b0; dbg_valid = 1'b0;

    // Idle cycle: strobe drops, address/data hold
    step();
    check("idle_we", rf_we, 0);
    check("idle_a3_hold", rf_a3, first_is_dbg ? 1 : 2);

    // Single writeback
    wb_valid = 1'b1; wb_addr = 5; wb_data = 32'hDEAD_BEEF;
    #1;
    check("wb_single_ready", wb_ready, 1);
    step();
    wb_valid = 1'b0;
    check("wb_single_we", rf_we, 1);
    check("wb_single_a3", rf_a3, 5);
    check("wb_single_wd3", rf_wd3, 32'hDEAD_BEEF);

    // Debug write to x0 is accepted and dropped
    dbg_valid = 1'b1; dbg_addr = 0; dbg_data = 32'h1234;
    #1;
    check("dbg_x0_ready", dbg_ready, 1);
    step();
    dbg_valid = 1'b0;
    check("dbg_x0_we", rf_we, 0);

    // Directed mix including withdrawn requests; model checks every cycle
    for (int i = 0; i < 12; i++) begin
      wb_valid  = (i % 3) != 2;
      wb_addr   = AW'(i + 3);
      wb_data   = 32'hA000_0000 + i;
      dbg_valid = (i % 4) < 2;
      dbg_addr  = AW'((i * 5) % NREG);
      dbg_data  = 32'hB000_0000 + i;
      step();
    end
    wb_valid = 1'b0; dbg_valid = 1'b0;

    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule

// File: doc/rf_wport_arbiter.md
# rf_wport_arbiter

Write-port controller for the 32x32 register file (`we3`/`a3`/`wd3` port). After reset it sequences a clear of x1..x31 to zero, then shares the single write port between two requesters, the core writeback path and a debug/loader port, using round-robin arbitration with valid/ready handshakes. Outputs are registered and connect directly to the register file write port; the read ports are untouched.

## Interface
Parameters:
- `XLEN`, 32: data width.
- `AW`, 5: register address width; 2**AW registers.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wb_valid`  in  1  writeback request.
- `wb_addr`  in  AW  writeback destination register.
- `wb_data`  in  XLEN  writeback data.
- `wb_ready`  out  1  writeback request accepted this cycle (combinational).
- `dbg_valid`  in  1  debug write request.
- `dbg_addr`  in  AW  debug destination register.
- `dbg_data`  in  XLEN  debug data.
- `dbg_ready`  out  1  debug request accepted this cycle (combinational).
- `rf_we`  out  1  to register file `we3`, registered.
- `rf_a3`  out  AW  to register file `a3`, registered.
- `rf_wd3`  out  XLEN  to register file `wd3`, registered.
- `clear_done`  out  1  high once the clear sequence has completed; stays high until reset.

## Operation
- State machine with two states: CLEAR and RUN. Reset enters CLEAR, with `cnt`=1 and `last`=1 (last grant = dbg).
- CLEAR:
  - Each cycle drives `rf_we`=1, `rf_a3`=`cnt`, `rf_wd3`=0, then increments `cnt`.
  - After the cycle that issues `cnt`=2**AW-1, the block moves to RUN and sets `clear_done`=1.
  - Both readies are held 0 throughout CLEAR.
- RUN, arbitration:
  - If only one requester is valid, it wins.
  - If both are valid, the requester not equal to `last` wins.
  - `last` updates on every grant.
  - At most one ready is high per cycle. A ready is high only when the corresponding valid is high.
- Accepted request: registers `rf_a3`=addr and `rf_wd3`=data on the next edge. `rf_we` is set to 1 unless addr==0.
  - A write to x0 is accepted (ready=1) but produces `rf_we`=0, so it is silently dropped.
- No accepted request in a cycle: the next `rf_we` is 0. `rf_a3` and `rf_wd3` hold their previous values.
- Requesters must hold valid, addr and data stable until ready. Deasserting valid before ready withdraws the request.

## Timing
- Reset values: `rf_we`=0, `rf_a3`=0, `rf_wd3`=0, `wb_ready`=0, `dbg_ready`=0, `clear_done`=0.
- Clear sequence:
  - `rf_we` is high for exactly 2**AW-1 consecutive cycles starting at the first clock edge after reset deasserts.
  - `clear_done` rises on the same edge that drops the final clear write.
  - The first request can be accepted in the cycle after that edge.
- Latency: a handshake at edge N drives `rf_we`/`rf_a3`/`rf_wd3` during cycle N..N+1; the register file writes at edge N+1.
- Throughput: one write per cycle. Under continuous dual contention the grants alternate wb, dbg, wb, ...
- Reset asserted mid-clear or mid-RUN: all outputs return to their reset values immediately (asynchronously), and the clear sequence restarts from x1.
- Readies are combinational from valids, the state and `last`. There is no combinational path from any input to `rf_*`.

## Configuration
- `RF_WPORT_CLEAR_EN` defined: CLEAR state and counter are present, and the block behaves as above.
- Not defined:
  - Reset enters RUN directly.
  - `clear_done` is constant 1.
  - The counter is removed.
  - The first request is acceptable in the first cycle after reset deasserts.

## Test plan
- Reset, then release: `rf_we`=1 for 31 cycles with `rf_a3`=1..31 and `rf_wd3`=0; `clear_done` rises after x31; both readies are 0 during clear.
- After clear, `wb_valid`=1, addr=5, data=0xDEADBEEF: `wb_ready`=1 the same cycle; the next cycle shows `rf_we`=1, `rf_a3`=5, `rf_wd3`=0xDEADBEEF.
- wb and dbg both valid for 4 cycles (wb→x1/0x11, dbg→x2/0x22): grants go dbg? No — `last`=dbg after reset, so the order is wb, dbg, wb, dbg. Exactly one ready per cycle, and `rf_a3` alternates 1, 2, 1, 2.
- `dbg_valid` with addr=0, data=0x1234: `dbg_ready`=1, and the next cycle `rf_we`=0.
- Reset asserted on the 10th clear cycle: outputs go to 0 immediately; after release the clear restarts at `rf_a3`=1.
- With `RF_WPORT_CLEAR_EN` undefined: `clear_done`=1, and `wb_valid` to x7 in the first cycle after reset release produces `rf_we`=1, `rf_a3`=7 the next cycle.
